match_ctrl: RTL and testbench
=============================

# match_ctrl

Parametrised penalty-shootout match controller; the next generation of the game state selector. It sits between the mouse/shot-evaluation logic and the screen selector. It sequences start, shoot and keep phases over a configurable number of rounds, keeps both scores, enforces a per-phase shot timeout and decides the outcome. It supports solo mode (shoot only) and versus mode (shoot and keep alternating), with early termination when the trailing side cannot catch up.

## Interface
Parameters:
- ROUNDS, 5: regulation rounds; at least 1 and at most 2^RND_W−1.
- SHOT_TIMEOUT, 200_000_000: clock cycles allowed per phase before a miss is forced.
- SCORE_W, 4: score counter width; scores saturate.
- RND_W, 4: round counter width.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset, synchronous, active-low.
- solo_enable  in  1  mode select; sampled only on the START→SHOOT transition.
- left_clicked  in  1  mouse left button level; edge-detected internally.
- shot_valid  in  1  one-cycle pulse from shot evaluation when the current phase resolves.
- shot_goal  in  1  qualifies shot_valid; 1 means a goal was scored.
- state  out  3  match_pkg::state_t: START, SHOOT, KEEP, END.
- outcome  out  2  match_pkg::outcome_t: NONE, WIN, LOSE, DRAW.
- score_player  out  SCORE_W  goals scored by the player.
- score_opp  out  SCORE_W  goals conceded.
- round_idx  out  RND_W  current round, counting from 0.
- solo_mode  out  1  latched mode of the running match.
- shot_arm  out  1  one-cycle pulse on entry to SHOOT or KEEP.

## Operation
- Click event: left_clicked is 1 and its registered previous value is 0.
  - The previous-value register resets to 1, so a button held through reset does not produce a click.
- START:
  - On a click event: clear scores, round_idx and outcome; latch solo_mode from solo_enable; go to SHOOT.
- SHOOT:
  - Phase resolves on shot_valid, or when the timer expires (counts as a miss).
  - A goal increments score_player.
  - Versus mode: go to KEEP.
  - Solo mode: increment round_idx; go to END after ROUNDS shots, otherwise re-enter SHOOT.
- KEEP:
  - Resolves the same way; a goal increments score_opp.
  - Then increment round_idx and return to SHOOT, unless an end condition holds.
- Timer:
  - Loaded with SHOT_TIMEOUT−1 on each phase entry; decrements every cycle.
  - Expires when it reaches 0 with no shot_valid.
  - If shot_valid arrives in the expiry cycle, shot_valid wins.
- Versus early end:
  - Checked after every phase during regulation.
  - If one score exceeds the other side's score plus its remaining regulation attempts, go to END.
- Versus regulation end:
  - After KEEP of round ROUNDS−1: a higher player score gives WIN; a lower one gives LOSE.
  - A tie gives DRAW, or continues as sudden death (see Configuration).
- Solo outcome: WIN if 2·score_player > ROUNDS, otherwise LOSE.
- END:
  - Outcome and scores hold.
  - A click event returns to START; outcome goes back to NONE on START entry.
- shot_valid outside SHOOT/KEEP is ignored.
- solo_enable changes during a match are ignored.
- Scores saturate at 2^SCORE_W−1; round_idx saturates at 2^RND_W−1.

## Timing
- All outputs are registered. Every output resets to 0/NONE; state resets to START.
- A click event or shot_valid in cycle n produces the new state, scores and round_idx in cycle n+1.
- shot_arm is high in the first cycle of each SHOOT/KEEP phase, i.e. cycle n+1.
- A timeout miss takes effect SHOOT_TIMEOUT cycles after phase entry.
- Reset mid-match: in the cycle after rst is sampled low, every output is back at its reset value, state is START and the timer is cleared.

## Configuration
- SUDDEN_DEATH_EN defined:
  - A versus tie after regulation continues with SHOOT/KEEP pairs.
  - After each pair, unequal scores give WIN or LOSE; equal scores continue play.
  - round_idx saturates; play continues after saturation.
- SUDDEN_DEATH_EN undefined: a versus tie after regulation gives END with outcome DRAW.
- Solo mode behaves the same with or without the macro.

## Structure
- Package match_pkg holds:
  - state_t: START=0, SHOOT=1, KEEP=2, END=3.
  - outcome_t: NONE=0, WIN=1, LOSE=2, DRAW=3.
- Sub-module match_timer holds the phase countdown.
  - Inputs: load, clear.
  - Output: expired.
  - Parameter: SHOT_TIMEOUT; counter width is $clog2(SHOT_TIMEOUT).
- The FSM, scoring and edge detection live in match_ctrl.

## Test plan
Run with ROUNDS=3 and SHOT_TIMEOUT=16.
- Hold left_clicked high through reset and then release it → state stays START. A later 0→1 transition → SHOOT next cycle, with shot_arm pulsing for 1 cycle.
- Solo mode with goals 1,1,0 → score_player=2, state END, outcome WIN. Goals 1,0,0 → outcome LOSE.
- Versus mode, player scores 2 and keeper concedes 0 by KEEP of round 1 → END after that KEEP with outcome WIN, round_idx=1 (early termination).
- Versus mode, no shot_valid → each phase times out after 16 cycles as a miss → score 0:0 at the end.
  - SUDDEN_DEATH_EN undefined → DRAW.
  - SUDDEN_DEATH_EN defined → round 3 starts; a goal then a save → WIN.
- shot_valid with shot_goal=1 in the timer expiry cycle → counted as a goal. Pull rst low mid-KEEP → all outputs at reset values next cycle.

Source files
------------

// File: rtl/match_pkg.sv
// Shared types for the penalty-shootout match controller.
// Phase and outcome encodings seen by the screen selector.
package match_pkg;

    typedef enum logic [2:0] {
        START = 3'd0,
        SHOOT = 3'd1,
        KEEP  = 3'd2,
        END   = 3'd3
    } state_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        WIN  = 2'd1,
        LOSE = 2'd2,
        DRAW = 2'd3
    } outcome_t;

endpackage

// File: rtl/match_timer.sv
// Per-phase shot countdown; expired is high while the count sits at zero.
// load restarts the phase window, clear parks the counter.
module match_timer #(
    parameter int SHOT_TIMEOUT = 200_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic clear,
    output logic expired
);

    localparam int CW = (SHOT_TIMEOUT > 1) ? $clog2(SHOT_TIMEOUT) : 1;
    localparam logic [CW-1:0] LOAD_V = CW'(SHOT_TIMEOUT - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= LOAD_V;
        end else if (r_count != '0) begin
            r_count <= r_count - CW'(1);
        end
    end

    assign expired = (r_count == '0);

endmodule

// File: rtl/match_ctrl.sv
// Penalty-shootout match FSM: phases, scoring, early end and outcome.
// Define SUDDEN_DEATH_EN to replay SHOOT/KEEP pairs after a versus tie.
module match_ctrl
    import match_pkg::*;
#(
    parameter int ROUNDS       = 5,
    parameter int SHOT_TIMEOUT = 200_000_000,
    parameter int SCORE_W      = 4,
    parameter int RND_W        = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               solo_enable,
    input  logic               left_clicked,
    input  logic               shot_valid,
    input  logic               shot_goal,
    output state_t             state,
    output outcome_t           outcome,
    output logic [SCORE_W-1:0] score_player,
    output logic [SCORE_W-1:0] score_opp,
    output logic [RND_W-1:0]   round_idx,
    output logic               solo_mode,
    output logic               shot_arm
);

    localparam int CW = SCORE_W + RND_W + 2;
    localparam logic [RND_W-1:0] ROUNDS_R = RND_W'(ROUNDS);
    localparam logic [RND_W-1:0] LAST_R   = RND_W'(ROUNDS - 1);

    state_t             r_state;
    outcome_t           r_outcome;
    logic [SCORE_W-1:0] r_score_p;
    logic [SCORE_W-1:0] r_score_o;
    logic [RND_W-1:0]   r_round;
    logic               r_solo;
    logic               r_arm;
    logic               r_prev_click;

    logic               w_click;
    logic               w_expired;
    logic               w_resolve;
    logic               w_goal;
    logic               w_regular;
    logic               w_last;
    logic               w_lead_p;
    logic               w_lead_o;
    logic               w_end;
    logic               w_load;
    logic               w_clear;
    outcome_t           w_out;
    logic [SCORE_W-1:0] w_ps_nxt;
    logic [SCORE_W-1:0] w_po_nxt;
    logic [RND_W-1:0]   w_round_inc;
    logic [CW-1:0]      w_ps_x;
    logic [CW-1:0]      w_po_x;
    logic [CW-1:0]      w_rem_p;
    logic [CW-1:0]      w_rem_o;

    assign w_click   = left_clicked && !r_prev_click;
    assign w_goal    = shot_valid && shot_goal;
    assign w_resolve = (r_state == SHOOT || r_state == KEEP)
                    && (shot_valid || w_expired);
    assign w_regular = (r_round < ROUNDS_R);
    assign w_last    = (r_round == LAST_R);
    assign w_round_inc = (&r_round) ? r_round : r_round + RND_W'(1);

    always_comb begin
        w_ps_nxt = r_score_p;
        w_po_nxt = r_score_o;
        if (r_state == SHOOT && w_goal && !(&r_score_p))
            w_ps_nxt = r_score_p + SCORE_W'(1);
        if (r_state == KEEP && w_goal && !(&r_score_o))
            w_po_nxt = r_score_o + SCORE_W'(1);
        w_ps_x  = CW'(w_ps_nxt);
        w_po_x  = CW'(w_po_nxt);
        // Attempts still owed to each side after the phase now resolving
        w_rem_p = CW'(LAST_R - r_round);
        w_rem_o = (r_state == SHOOT) ? CW'(ROUNDS_R - r_round) : w_rem_p;
        w_lead_p = w_ps_x > (w_po_x + w_rem_o);
        w_lead_o = w_po_x > (w_ps_x + w_rem_p);
    end

    always_comb begin
        w_end = 1'b0;
        w_out = NONE;
        if (w_resolve) begin
            if (r_state == SHOOT) begin
                if (r_solo) begin
                    w_end = (r_round >= LAST_R);
                    w_out = ((w_ps_x << 1) > CW'(ROUNDS_R)) ? WIN : LOSE;
                end else if (w_regular && (w_lead_p || w_lead_o)) begin
                    w_end = 1'b1;
                    w_out = w_lead_p ? WIN : LOSE;
                end
            end else if (w_regular) begin
                if (w_lead_p || w_lead_o) begin
                    w_end = 1'b1;
                    w_out = w_lead_p ? WIN : LOSE;
                end else if (w_last) begin
`ifndef SUDDEN_DEATH_EN
                    w_end = 1'b1;
                    w_out = DRAW;
`endif
                end
            end else if (w_ps_x != w_po_x) begin
                w_end = 1'b1;
                w_out = (w_ps_x > w_po_x) ? WIN : LOSE;
            end
        end
    end

    assign w_load  = (r_state == START && w_click) || (w_resolve && !w_end);
    assign w_clear = w_resolve && w_end;

    match_timer #(
        .SHOT_TIMEOUT (SHOT_TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (w_load),
        .clear   (w_clear),
        .expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= START;
            r_outcome    <= NONE;
            r_score_p    <= '0;
            r_score_o    <= '0;
            r_round      <= '0;
            r_solo       <= 1'b0;
            r_arm        <= 1'b0;
            r_prev_click <= 1'b1;
        end else begin
            r_prev_click <= left_clicked;
            r_arm        <= 1'b0;
            unique case (r_state)
                START: if (w_click) begin
                    r_score_p <= '0;
                    r_score_o <= '0;
                    r_round   <= '0;
                    r_outcome <= NONE;
                    r_solo    <= solo_enable;
                    r_state   <= SHOOT;
                    r_arm     <= 1'b1;
                end
                SHOOT: if (w_resolve) begin
                    r_score_p <= w_ps_nxt;
                    if (r_solo)
                        r_round <= w_round_inc;
                    if (w_end) begin
                        r_state   <= END;
                        r_outcome <= w_out;
                    end else begin
                        r_state <= r_solo ? SHOOT : KEEP;
                        r_arm   <= 1'b1;
                    end
                end
                KEEP: if (w_resolve) begin
                    r_score_o <= w_po_nxt;
                    if (w_end) begin
                        r_state   <= END;
                        r_outcome <= w_out;
                    end else begin
                        r_round <= w_round_inc;
                        r_state <= SHOOT;
                        r_arm   <= 1'b1;
                    end
                end
                END: if (w_click) begin
                    r_state   <= START;
                    r_outcome <= NONE;
                end
                default: r_state <= START;
            endcase
        end
    end

    assign state        = r_state;
    assign outcome      = r_outcome;
    assign score_player = r_score_p;
    assign score_opp    = r_score_o;
    assign round_idx    = r_round;
    assign solo_mode    = r_solo;
    assign shot_arm     = r_arm;

endmodule

// File: tb/tb_match_ctrl.sv
// Bench for match_ctrl: directed shootout scenarios plus random matches
// scored against a per-attempt model of the match rules.
module tb_match_ctrl;
    import match_pkg::*;

    localparam int R = 3;
    localparam int T = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       solo_enable = 1'b0;
    logic       left_clicked = 1'b1;
    logic       shot_valid = 1'b0;
    logic       shot_goal = 1'b0;
    state_t     state;
    outcome_t   outcome;
    logic [3:0] score_player;
    logic [3:0] score_opp;
    logic [3:0] round_idx;
    logic       solo_mode;
    logic       shot_arm;

    match_ctrl #(
        .ROUNDS       (R),
        .SHOT_TIMEOUT (T),
        .SCORE_W      (4),
        .RND_W        (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .solo_enable  (solo_enable),
        .left_clicked (left_clicked),
        .shot_valid   (shot_valid),
        .shot_goal    (shot_goal),
        .state        (state),
        .outcome      (outcome),
        .score_player (score_player),
        .score_opp    (score_opp),
        .round_idx    (round_idx),
        .solo_mode    (solo_mode),
        .shot_arm     (shot_arm)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    bit m_solo;
    bit m_done;
    int m_k;
    int m_ps;
    int m_po;
    int m_out;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int min15(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    // Match rules in terms of attempts taken: k phases played so far.
    task automatic model_phase(input bit scored);
        bit keep;
        int sp, so, rp, ro;
        keep = !m_solo && (m_k % 2 == 1);
        m_k++;
        if (scored) begin
            if (keep) m_po = min15(m_po + 1);
            else      m_ps = min15(m_ps + 1);
        end
        if (m_solo) begin
            if (m_k >= R) begin
                m_done = 1;
                m_out  = (2 * m_ps > R) ? 1 : 2;
            end
        end else if (m_k <= 2 * R) begin
            sp = (m_k + 1) / 2;
            so = m_k / 2;
            rp = R - sp;
            ro = R - so;
            if (m_ps > m_po + ro) begin
                m_done = 1; m_out = 1;
            end else if (m_po > m_ps + rp) begin
                m_done = 1; m_out = 2;
            end else if (m_k == 2 * R) begin
`ifndef SUDDEN_DEATH_EN
                m_done = 1; m_out = 3;
`endif
            end
        end else if (m_k % 2 == 0 && m_ps != m_po) begin
            m_done = 1;
            m_out  = (m_ps > m_po) ? 1 : 2;
        end
    endtask

    task automatic check_model(input string tag);
        int e_state, e_round;
        if (m_done)      e_state = 3;
        else if (m_solo) e_state = 1;
        else             e_state = (m_k % 2 == 0) ? 1 : 2;
        if (m_solo)      e_round = min15(m_k);
        else if (m_done) e_round = min15((m_k - 1) / 2);
        else             e_round = min15(m_k / 2);
        check({tag, ".state"}, state, e_state);
        check({tag, ".sp"}, score_player, m_ps);
        check({tag, ".so"}, score_opp, m_po);
        check({tag, ".round"}, round_idx, e_round);
        check({tag, ".outcome"}, outcome, m_done ? m_out : 0);
        check({tag, ".arm"}, shot_arm, m_done ? 0 : 1);
    endtask

    // kind 0: shot after dly cycles, 1: timeout, 2: shot in expiry cycle
    task automatic run_phase(input int kind, input bit goal, input int dly);
        int exp_ph, d;
        bit scored;
        exp_ph = (m_solo || m_k % 2 == 0) ? 1 : 2;
        if (kind == 1) begin
            shot_goal = 1'b1;
            for (int i = 0; i < T - 1; i++) begin
                solo_enable = 1'($urandom);
                tick();
                if (i == 0) check("arm_low", shot_arm, 0);
            end
            check("pre_timeout", state, exp_ph);
            tick();
            scored = 1'b0;
        end else begin
            d = (kind == 2) ? T - 1 : dly;
            for (int i = 0; i < d; i++) begin
                solo_enable = 1'($urandom);
                tick();
                if (i == 0) check("arm_low", shot_arm, 0);
            end
            if (d > 0) check("phase_hold", state, exp_ph);
            shot_valid = 1'b1;
            shot_goal  = goal;
            tick();
            scored = goal;
        end
        shot_valid = 1'b0;
        shot_goal  = 1'($urandom);
        model_phase(scored);
        check_model("phase");
    endtask

    task automatic start_match(input bit solo);
        left_clicked = 1'b0;
        tick();
        solo_enable  = solo;
        left_clicked = 1'b1;
        tick();
        m_solo = solo;
        m_done = 0;
        m_k    = 0;
        m_ps   = 0;
        m_po   = 0;
        m_out  = 0;
        check("start.state", state, 1);
        check("start.arm", shot_arm, 1);
        check("start.solo", solo_mode, solo);
        check("start.sp", score_player, 0);
        check("start.so", score_opp, 0);
        check("start.round", round_idx, 0);
        check("start.outcome", outcome, 0);
    endtask

    task automatic finish_match();
        shot_valid = 1'b1;
        shot_goal  = 1'b1;
        tick();
        shot_valid = 1'b0;
        check("end.hold_state", state, 3);
        check("end.hold_sp", score_player, m_ps);
        check("end.hold_so", score_opp, m_po);
        check("end.hold_out", outcome, m_out);
        left_clicked = 1'b0;
        tick();
        left_clicked = 1'b1;
        tick();
        check("restart.state", state, 0);
        check("restart.outcome", outcome, 0);
        shot_valid = 1'b1;
        tick();
        shot_valid = 1'b0;
        check("start_ignore", state, 0);
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".state"}, state, 0);
        check({tag, ".outcome"}, outcome, 0);
        check({tag, ".sp"}, score_player, 0);
        check({tag, ".so"}, score_opp, 0);
        check({tag, ".round"}, round_idx, 0);
        check({tag, ".solo"}, solo_mode, 0);
        check({tag, ".arm"}, shot_arm, 0);
    endtask

    initial begin
        int cnt;
        int kind;
        rst = 1'b0;
        left_clicked = 1'b1;
        repeat (3) tick();
        check_reset("reset");
        rst = 1'b1;
        repeat (2) tick();
        check("held_click", state, 0);
        left_clicked = 1'b0;
        tick();
        check("release", state, 0);

        start_match(1'b1);
        run_phase(0, 1'b1, 3);
        run_phase(0, 1'b1, 0);
        run_phase(0, 1'b0, 5);
        check("solo_win.sp", score_player, 2);
        check("solo_win.out", outcome, 1);
        finish_match();

        start_match(1'b1);
        run_phase(0, 1'b1, 1);
        run_phase(0, 1'b0, 2);
        run_phase(0, 1'b0, 4);
        check("solo_lose.out", outcome, 2);
        finish_match();

        start_match(1'b0);
        run_phase(0, 1'b1, 2);
        run_phase(0, 1'b0, 1);
        run_phase(0, 1'b1, 0);
        run_phase(0, 1'b0, 3);
        check("early.state", state, 3);
        check("early.round", round_idx, 1);
        check("early.out", outcome, 1);
        finish_match();

        start_match(1'b0);
        cnt = 0;
        while (!m_done && cnt < 20) begin
            if (cnt < 6) run_phase(1, 1'b0, 0);
            else         run_phase(0, cnt == 6, 2);
            cnt++;
        end
`ifdef SUDDEN_DEATH_EN
        check("sd.out", outcome, 1);
        check("sd.round", round_idx, 3);
`else
        check("draw.out", outcome, 3);
`endif
        finish_match();

        start_match(1'b1);
        run_phase(2, 1'b1, 0);
        check("expiry_goal.sp", score_player, 1);
        run_phase(2, 1'b0, 0);
        run_phase(1, 1'b0, 0);
        finish_match();

        start_match(1'b0);
        run_phase(0, 1'b1, 2);
        repeat (3) tick();
        rst = 1'b0;
        left_clicked = 1'b0;
        tick();
        check_reset("midkeep");
        rst = 1'b1;
        tick();
        check("post_reset", state, 0);

        for (int g = 0; g < 25; g++) begin
            start_match(1'($urandom));
            cnt = 0;
            while (!m_done && cnt < 200) begin
                kind = $urandom_range(0, 9);
                if (kind == 0)
                    run_phase(1, 1'b0, 0);
                else if (kind == 1)
                    run_phase(2, 1'($urandom), 0);
                else
                    run_phase(0, 1'($urandom), $urandom_range(0, T - 2));
                cnt++;
            end
            check("match_done", m_done, 1);
            finish_match();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
